// File: rtl/conv_channel_injector_pkg.sv
// Shared types, LFSR constants and helpers for the coded-symbol channel model.
// Imported by the LFSR sub-block and by the injector top.
package conv_chan_pkg;

    typedef enum logic [1:0] {
        CH_CLEAN    = 2'd0,
        CH_PERIODIC = 2'd1,
        CH_BURST    = 2'd2,
        CH_RANDOM   = 2'd3
    } chan_mode_t;

    typedef enum logic {
        B_IDLE  = 1'b0,
        B_BURST = 1'b1
    } burst_st_t;

    // Fibonacci taps 16,14,13,11 expressed as state bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/conv_channel_injector_if.sv
// Symbol stream between encoder, channel model and decoder.
// The injector is the slave: it consumes in_* and produces out_*.
interface conv_chan_if #(
    parameter int SYM_W = 2
);
    logic             in_valid;
    logic [SYM_W-1:0] in_sym;
    logic             out_valid;
    logic [SYM_W-1:0] out_sym;
    logic [SYM_W-1:0] out_err_mask;

    modport master (
        output in_valid,
        output in_sym,
        input  out_valid,
        input  out_sym,
        input  out_err_mask
    );

    modport slave (
        input  in_valid,
        input  in_sym,
        output out_valid,
        output out_sym,
        output out_err_mask
    );
endinterface

// File: rtl/conv_channel_injector_lfsr.sv
// 16-bit Fibonacci LFSR, left-shifting with feedback into bit 0.
// An all-zero seed would lock up, so it is replaced by the default seed.
module chan_lfsr16
    import conv_chan_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [15:0] o_state
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb    = ^(r_state & LFSR_TAPS);
    assign o_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED_EFF;
        end else if (i_en) begin
            r_state <= {r_state[14:0], w_fb};
        end
    end

endmodule

// File: rtl/conv_channel_injector.sv
// Channel model between convolutional encoder and Viterbi decoder: forwards each
// symbol with one cycle of latency, XOR-injecting errors under a selectable mode.
module conv_channel_injector
    import conv_chan_pkg::*;
#(
    parameter int          SYM_W       = 2,
    parameter int          PERIOD_LOG2 = 3,
    parameter int          BURST_LEN   = 4,
    parameter int          WINDOW      = 256,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic [7:0]       thresh_i,
    conv_chan_if.slave       ch,
    output logic [CNT_W-1:0] inj_count_o,
    output logic [CNT_W-1:0] bad_bit_count_o,
    output logic [CNT_W-1:0] sym_count_o,
    output logic             window_done_o
);

    localparam int                BCNT_W       = PERIOD_LOG2 + 1;
    localparam logic [CNT_W-1:0]  WIN_C        = CNT_W'(WINDOW);
    localparam logic [BCNT_W-1:0] BURST_RELOAD = BCNT_W'(BURST_LEN - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             r_valid;
    logic [SYM_W-1:0] r_sym;
    logic [SYM_W-1:0] r_mask;
    logic [CNT_W-1:0] r_inj;
    logic [CNT_W-1:0] r_bad;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    burst_st_t         r_bst;
    burst_st_t         w_bst_next;
    logic [BCNT_W-1:0] r_bcnt;
    logic [BCNT_W-1:0] w_bcnt_next;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [15:0]      w_lfsr;
    chan_mode_t       w_mode;
    logic             w_in_win;
    logic             w_trigger;
    logic [SYM_W-1:0] w_cand;
    logic [SYM_W-1:0] w_cand_fix;
    logic             w_inject;
    logic [SYM_W-1:0] w_mask;
    logic [3:0]       w_pop;
    logic [CNT_W:0]   w_bad_sum;
    logic [CNT_W-1:0] w_bad_next;
    logic [CNT_W-1:0] w_inj_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_unused_lfsr;

    chan_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (ch.in_valid),
        .o_state (w_lfsr)
    );

    assign w_mode     = chan_mode_t'(mode_i);
    assign w_in_win   = (r_cnt < WIN_C);
    assign w_trigger  = &r_cnt[PERIOD_LOG2-1:0];
    assign w_cand     = w_lfsr[SYM_W-1:0];
    // An injection must always flip something, so an all-zero candidate becomes LSB-only
    assign w_cand_fix = (w_cand == '0) ? SYM_W'(1) : w_cand;
    assign w_mask     = w_inject ? w_cand_fix : '0;
    assign w_unused_lfsr = &{1'b0, w_lfsr[7:0]};

    // Burst FSM and injection decision; non-burst modes hold the FSM in IDLE
    always_comb begin
        w_bst_next  = r_bst;
        w_bcnt_next = r_bcnt;
        w_inject    = 1'b0;
        if (ch.in_valid) begin
            w_bst_next  = B_IDLE;
            w_bcnt_next = '0;
            case (w_mode)
                CH_PERIODIC: begin
                    w_inject = w_in_win && w_trigger;
                end
                CH_RANDOM: begin
                    w_inject = w_in_win && (w_lfsr[15:8] < thresh_i);
                end
                CH_BURST: begin
                    if (!w_in_win) begin
                        w_inject = 1'b0;
                    end else if (r_bst == B_BURST) begin
                        w_inject    = 1'b1;
                        w_bcnt_next = r_bcnt - BCNT_W'(1);
                        w_bst_next  = (r_bcnt == BCNT_W'(1)) ? B_IDLE : B_BURST;
                    end else if (w_trigger) begin
                        w_inject    = 1'b1;
                        w_bcnt_next = BURST_RELOAD;
                        w_bst_next  = (BURST_RELOAD != '0) ? B_BURST : B_IDLE;
                    end
                end
                default: begin
                    w_inject = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bst  <= B_IDLE;
            r_bcnt <= '0;
        end else begin
            r_bst  <= w_bst_next;
            r_bcnt <= w_bcnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    assign w_pop      = popcount(8'(w_mask));
    assign w_bad_sum  = {1'b0, r_bad} + {{(CNT_W-3){1'b0}}, w_pop};
    assign w_bad_next = w_bad_sum[CNT_W] ? {CNT_W{1'b1}} : w_bad_sum[CNT_W-1:0];
    assign w_inj_next = (&r_inj) ? r_inj : r_inj + CNT_W'(1);
    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sym   <= '0;
            r_mask  <= '0;
            r_inj   <= '0;
            r_bad   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (ch.in_valid) begin
            r_valid <= 1'b1;
            r_sym   <= ch.in_sym ^ w_mask;
            r_mask  <= w_mask;
            r_cnt   <= w_cnt_next;
            r_done  <= r_done | (w_cnt_next >= WIN_C);
            if (w_inject) begin
                r_inj <= w_inj_next;
                r_bad <= w_bad_next;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign ch.out_valid     = r_valid;
    assign ch.out_sym       = r_sym;
    assign ch.out_err_mask  = r_mask;
    assign inj_count_o      = r_inj;
    assign bad_bit_count_o  = r_bad;
    assign sym_count_o      = r_cnt;
    assign window_done_o    = r_done;

endmodule
